keypad_scanner: RTL

Scans a 4x4 active-low key matrix and debounces the result. Each accepted key press is shifted into a 32-bit, 8-digit hex entry register. It is the input-side counterpart of the multiplexed seven-segment display path: strobes go out one-cold, readback comes in, and `val_out` connects directly to the display controller's 32-bit value input so typed digits appear on the rightmost digit and scroll left.

---
 rtl/keypad_scanner_pkg.sv | 39 +++
 rtl/keypad_scanner_if.sv | 31 +++
 rtl/keypad_debounce.sv | 157 +++++++++++++++
 rtl/keypad_scanner.sv | 111 +++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types, widths and helper functions for the 4x4 keypad
// scanner. Imported by the interface, the debounce FSM and the top level.
package keypad_pkg;

  localparam int KEY_W              = 4;
  localparam int REPEAT_DELAY_SCANS = 64;
  localparam int REPEAT_RATE_SCANS  = 16;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD,
    RELEASE
  } deb_state_t;

  typedef enum logic [1:0] {
    NONE,
    ONE,
    MULTI
  } scan_class_t;

  // Classify a full-matrix press map by how many keys are down.
  function automatic scan_class_t classify(input logic [15:0] map);
    int n;
    n = $countones(map);
    if (n == 0)      classify = NONE;
    else if (n == 1) classify = ONE;
    else             classify = MULTI;
  endfunction

  // Code of the lowest pressed key; only meaningful when exactly one is down.
  function automatic logic [KEY_W-1:0] key_code(input logic [15:0] map);
    key_code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (map[i[3:0]]) key_code = KEY_W'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: matrix strobes/readback, clear request and the accepted
// key / entry-register outputs. The scanner sits on the slave side.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [3:0]       row_in;
  logic             clr_in;
  logic [3:0]       col_out;
  logic [KEY_W-1:0] key_out;
  logic             key_valid_out;
  logic [31:0]      val_out;

  modport master (
    output row_in,
    output clr_in,
    input  col_out,
    input  key_out,
    input  key_valid_out,
    input  val_out
  );

  modport slave (
    input  row_in,
    input  clr_in,
    output col_out,
    output key_out,
    output key_valid_out,
    output val_out
  );

endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: press/release debounce FSM evaluated once per full scan.
// Optional auto-repeat while a single key stays held is enabled by defining
// KEYPAD_AUTOREPEAT_EN; without it each press is reported exactly once.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_done,
  input  scan_class_t      scan_class,
  input  logic [KEY_W-1:0] scan_code,
  output logic             accept,
  output logic [KEY_W-1:0] accept_code
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] FIRST  = CW'(1);

  deb_state_t       state, state_next;
  logic [CW-1:0]    cnt, cnt_next, cnt_inc;
  logic [KEY_W-1:0] cand, cand_next;
  logic             hit;

  assign cnt_inc     = cnt + FIRST;
  assign accept_code = cand_next;

  // Next-state logic: advance only on the end-of-scan strobe.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    hit        = 1'b0;
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (scan_class == ONE) begin
            cand_next = scan_code;
            if (FIRST >= TARGET) begin
              state_next = HELD;
              cnt_next   = '0;
              hit        = 1'b1;
            end else begin
              state_next = PRESS;
              cnt_next   = FIRST;
            end
          end
        end
        PRESS: begin
          if (scan_class == ONE) begin
            if (scan_code == cand) begin
              if (cnt_inc >= TARGET) begin
                state_next = HELD;
                cnt_next   = '0;
                hit        = 1'b1;
              end else begin
                cnt_next = cnt_inc;
              end
            end else begin
              cand_next = scan_code;
              cnt_next  = FIRST;
            end
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        HELD: begin
          if (scan_class == NONE) begin
            if (FIRST >= TARGET) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              state_next = RELEASE;
              cnt_next   = FIRST;
            end
          end
        end
        RELEASE: begin
          if (scan_class == NONE) begin
            if (cnt_inc >= TARGET) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = HELD;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State, stable-scan counter and candidate key registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cand  <= cand_next;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_SCANS + 1);
  localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY_SCANS);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY_SCANS - REPEAT_RATE_SCANS);

  logic [RW-1:0] rpt, rpt_next, rpt_inc;
  logic          rpt_hit;

  assign rpt_inc = rpt + RW'(1);

  // Repeat timer: counts scans of the same single key while held; any other
  // scan result (or leaving HELD) cancels it.
  always_comb begin
    rpt_next = rpt;
    rpt_hit  = 1'b0;
    if (state != HELD) begin
      rpt_next = '0;
    end else if (scan_done) begin
      if (scan_class == ONE && scan_code == cand) begin
        if (rpt_inc == RPT_DELAY) begin
          rpt_hit  = 1'b1;
          rpt_next = RPT_RELOAD;
        end else begin
          rpt_next = rpt_inc;
        end
      end else begin
        rpt_next = '0;
      end
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpt <= '0;
    else        rpt <= rpt_next;
  end

  assign accept = hit | rpt_hit;
`else
  assign accept = hit;
`endif

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: one-cold column strobing of a 4x4 active-low matrix, row
// synchronization, press-map assembly and the 8-digit hex entry register.
// Define KEYPAD_AUTOREPEAT_EN to enable auto-repeat of a held key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_COUNT     = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic             clk_in,
  input logic             rst_n_in,
  keypad_scanner_if.slave kp
);

  localparam int DW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_COUNT - 1);

  logic [3:0]       row_meta, row_sync;
  logic [DW-1:0]    dwell;
  logic [1:0]       col_idx;
  logic             sample;
  logic [15:0]      map, map_next;
  logic [3:0]       bit_idx;
  logic             scan_done;
  scan_class_t      scan_class;
  logic [KEY_W-1:0] scan_code;
  logic             accept;
  logic [KEY_W-1:0] accept_code;

  // Two-flop synchronizer; resets to "all rows released".
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row_in;
      row_sync <= row_meta;
    end
  end

  assign sample     = (dwell == DWELL_LAST);
  assign kp.col_out = ~(4'b0001 << col_idx);

  // Dwell counter; the column rotates on the same cycle rows are sampled.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dwell   <= '0;
      col_idx <= '0;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Merge the current column's sampled rows into the press map.
  always_comb begin
    map_next = map;
    bit_idx  = '0;
    for (int r = 0; r < 4; r++) begin
      bit_idx           = {r[1:0], col_idx};
      map_next[bit_idx] = ~row_sync[r];
    end
  end

  // Press map register and end-of-scan strobe (column 3 sample).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      map       <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= sample && (col_idx == 2'd3);
      if (sample) map <= map_next;
    end
  end

  assign scan_class = classify(map);
  assign scan_code  = key_code(map);

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .scan_done  (scan_done),
    .scan_class (scan_class),
    .scan_code  (scan_code),
    .accept     (accept),
    .accept_code(accept_code)
  );

  // Report accepted keys and shift them into the entry register; a clear
  // on the accept cycle leaves only the new digit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      kp.key_out       <= '0;
      kp.key_valid_out <= 1'b0;
      kp.val_out       <= '0;
    end else begin
      kp.key_valid_out <= accept;
      if (accept) kp.key_out <= accept_code;
      if (kp.clr_in) begin
        kp.val_out <= accept ? {28'd0, accept_code} : 32'd0;
      end else if (accept) begin
        kp.val_out <= {kp.val_out[27:0], accept_code};
      end
    end
  end

endmodule
